// File: rtl/txarb.sv
// txarb: round-robin arbiter that shares one txuart among NREQ message requesters.
// Latency: request seen in IDLE at edge t -> grant/addr at t+1, first o_tx_stb at t+3; 3 cycles min between bytes.
// Backpressure: o_tx_stb/o_tx_data are held until an edge with !i_tx_busy (the handoff); one message completes before the next grant.
//
// Ports:
//   i_clk, i_reset_n          clock, synchronous active-low reset
//   i_req[NREQ]               level request, held until the matching o_done pulse
//   i_base/i_len[NREQ*AW]     per-requester start address and byte count, sampled at grant
//   o_grant[NREQ]             one-hot owner of the transmitter, 0 when idle
//   o_done[NREQ]              one-cycle completion pulse to the owner
//   o_busy                    high in every state except IDLE
//   o_mem_addr, i_mem_data    memory read port, data valid the cycle after the address
//   o_tx_stb, o_tx_data,
//   i_tx_busy                 txuart strobe/busy handshake
module txarb #(
  parameter int NREQ = 4,
  parameter int AW   = 11
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic [NREQ-1:0]   i_req,
  input  logic [NREQ*AW-1:0] i_base,
  input  logic [NREQ*AW-1:0] i_len,
  output logic [NREQ-1:0]   o_grant,
  output logic [NREQ-1:0]   o_done,
  output logic              o_busy,
  output logic [AW-1:0]     o_mem_addr,
  input  logic [7:0]        i_mem_data,
  output logic              o_tx_stb,
  output logic [7:0]        o_tx_data,
  input  logic              i_tx_busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, READ, SEND, DONE} state_t;

  state_t          state;
  logic [PW-1:0]   ptr;
  logic [AW-1:0]   cnt;

  logic            pick_vld;
  logic [PW-1:0]   pick_idx;
  logic [PW-1:0]   pick_nxt;
  logic [NREQ-1:0] pick_oh;
  logic [AW-1:0]   pick_base;
  logic [AW-1:0]   pick_len;

  // Round-robin pick. Both passes scan downward so the lowest matching index
  // is the last assignment; the second pass (indices at/above the pointer)
  // overrides the first (wrapped indices below the pointer).
  always_comb begin
    pick_vld  = 1'b0;
    pick_idx  = '0;
    pick_base = '0;
    pick_len  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (i_req[k] && (k < int'(ptr))) begin
        pick_vld  = 1'b1;
        pick_idx  = PW'(k);
        pick_base = i_base[k*AW +: AW];
        pick_len  = i_len[k*AW +: AW];
      end
    end
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (i_req[k] && (k >= int'(ptr))) begin
        pick_vld  = 1'b1;
        pick_idx  = PW'(k);
        pick_base = i_base[k*AW +: AW];
        pick_len  = i_len[k*AW +: AW];
      end
    end
    pick_nxt = (int'(pick_idx) == NREQ - 1) ? '0 : pick_idx + PW'(1);
    pick_oh  = NREQ'(1) << pick_idx;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state      <= IDLE;
      ptr        <= '0;
      cnt        <= '0;
      o_grant    <= '0;
      o_done     <= '0;
      o_busy     <= 1'b0;
      o_mem_addr <= '0;
      o_tx_stb   <= 1'b0;
      o_tx_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            o_grant    <= pick_oh;
            o_mem_addr <= pick_base;
            cnt        <= pick_len;
            ptr        <= pick_nxt;
            o_busy     <= 1'b1;
            if (pick_len == '0) begin
              // Empty message: straight to the completion pulse.
              o_done <= pick_oh;
              state  <= DONE;
            end else begin
              state <= LOAD;
            end
          end
        end
        LOAD: state <= READ;
        READ: begin
          o_tx_data <= i_mem_data;
          o_tx_stb  <= 1'b1;
          state     <= SEND;
        end
        SEND: begin
          if (o_tx_stb && !i_tx_busy) begin
            o_tx_stb <= 1'b0;
            cnt      <= cnt - AW'(1);
            if (cnt == AW'(1)) begin
              // o_done is registered, so it is raised here to be high in DONE.
              o_done <= o_grant;
              state  <= DONE;
            end else begin
              o_mem_addr <= o_mem_addr + AW'(1);
              state      <= LOAD;
            end
          end
        end
        DONE: begin
          o_done  <= '0;
          o_grant <= '0;
          o_busy  <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_txarb.sv
// tb_txarb: directed bench for txarb with a byte memory and a txuart busy model.
// Latency: checks grant/strobe timing, round-robin order, zero length, wrap, hold and reset.
// Backpressure: txuart model holds busy for a fixed count after each handoff, plus a manual hold.
module tb_txarb;

  localparam int NREQ = 4;
  localparam int AW   = 11;
  localparam int BUSY_LEN = 10;

  logic              i_clk = 1'b0;
  logic              i_reset_n = 1'b0;
  logic [NREQ-1:0]   i_req = '0;
  logic [NREQ*AW-1:0] i_base = '0;
  logic [NREQ*AW-1:0] i_len = '0;
  logic [NREQ-1:0]   o_grant;
  logic [NREQ-1:0]   o_done;
  logic              o_busy;
  logic [AW-1:0]     o_mem_addr;
  logic [7:0]        i_mem_data = '0;
  logic              o_tx_stb;
  logic [7:0]        o_tx_data;
  logic              i_tx_busy;

  txarb #(.NREQ(NREQ), .AW(AW)) dut (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_req      (i_req),
    .i_base     (i_base),
    .i_len      (i_len),
    .o_grant    (o_grant),
    .o_done     (o_done),
    .o_busy     (o_busy),
    .o_mem_addr (o_mem_addr),
    .i_mem_data (i_mem_data),
    .o_tx_stb   (o_tx_stb),
    .o_tx_data  (o_tx_data),
    .i_tx_busy  (i_tx_busy)
  );

  always #5 i_clk = ~i_clk;

  // Memory and txuart models
  logic [7:0] mem [0:2047];
  int         bcnt = 0;
  logic       hold_busy = 1'b0;
  assign i_tx_busy = hold_busy || (bcnt != 0);

  always @(posedge i_clk) begin
    i_mem_data <= mem[o_mem_addr];
    if (o_tx_stb && !i_tx_busy) bcnt <= BUSY_LEN;
    else if (bcnt != 0)         bcnt <= bcnt - 1;
  end

  // Event logs
  int   tx_q[$];
  int   addr_q[$];
  int   done_q[$];
  int   grant_q[$];
  int   stb_cnt = 0;
  logic [NREQ-1:0] prev_grant = '0;

  function automatic int oh2i(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  always @(posedge i_clk) begin
    if (o_tx_stb && !i_tx_busy) begin
      tx_q.push_back(int'(o_tx_data));
      addr_q.push_back(int'(o_mem_addr));
    end
    if (o_done != '0) done_q.push_back(oh2i(o_done));
    if (o_grant != '0 && prev_grant == '0) grant_q.push_back(oh2i(o_grant));
    prev_grant = o_grant;
    if (o_tx_stb) stb_cnt++;
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_msg(input int k, input int base, input int len);
    i_base[k*AW +: AW] = AW'(base);
    i_len[k*AW +: AW]  = AW'(len);
  endtask

  task automatic clear_logs();
    tx_q.delete(); addr_q.delete(); done_q.delete(); grant_q.delete();
    stb_cnt = 0;
  endtask

  // Wait for n done pulses; optionally drop each request while its o_done is seen.
  task automatic wait_done(input int n, input int budget, input logic drop);
    int cyc = 0;
    while (done_q.size() < n && cyc < budget) begin
      @(negedge i_clk);
      cyc++;
      if (drop) i_req = i_req & ~o_done;
    end
    chk("done_count", 32'(done_q.size()), 32'(n));
  endtask

  int hold_bad;
  int cyc;

  initial begin
    for (int a = 0; a < 2048; a++) mem[a] = 8'h00;

    // Reset state
    i_reset_n = 1'b0;
    repeat (2) @(negedge i_clk);
    chk("rst_grant", 32'(o_grant), 32'h0);
    chk("rst_done", 32'(o_done), 32'h0);
    chk("rst_busy", 32'(o_busy), 32'h0);
    chk("rst_stb", 32'(o_tx_stb), 32'h0);
    chk("rst_addr", 32'(o_mem_addr), 32'h0);
    chk("rst_data", 32'(o_tx_data), 32'h0);
    i_reset_n = 1'b1;
    @(negedge i_clk);

    // Round-robin with all four requesting continuously, len 1 each
    for (int k = 0; k < NREQ; k++) begin
      set_msg(k, 32'h020 + k, 1);
      mem[11'(32'h020 + k)] = 8'(32'hB0 + k);
    end
    clear_logs();
    i_req = 4'b1111;
    wait_done(6, 2000, 1'b0);
    i_req = 4'b0000;
    for (int i = 0; i < 6; i++) begin
      chk("rr_grant", 32'(grant_q[i]), 32'(i % 4));
      chk("rr_done", 32'(done_q[i]), 32'(i % 4));
      chk("rr_byte", 32'(tx_q[i]), 32'hB0 + 32'(i % 4));
    end

    // Pointer now at 2: requesters 0 and 3 -> 3 then 0
    clear_logs();
    i_req = 4'b1001;
    wait_done(2, 1000, 1'b1);
    chk("rr2_first", 32'(grant_q[0]), 32'd3);
    chk("rr2_second", 32'(grant_q[1]), 32'd0);

    // Single message with timing
    mem[11'h010] = 8'h41; mem[11'h011] = 8'h42; mem[11'h012] = 8'h43;
    set_msg(0, 32'h010, 3);
    clear_logs();
    i_req = 4'b0001;
    @(negedge i_clk);
    chk("sm_load_grant", 32'(o_grant), 32'h1);
    chk("sm_load_addr", 32'(o_mem_addr), 32'h010);
    chk("sm_load_busy", 32'(o_busy), 32'h1);
    chk("sm_load_stb", 32'(o_tx_stb), 32'h0);
    @(negedge i_clk);
    chk("sm_read_stb", 32'(o_tx_stb), 32'h0);
    @(negedge i_clk);
    chk("sm_send_stb", 32'(o_tx_stb), 32'h1);
    chk("sm_send_data", 32'(o_tx_data), 32'h41);
    wait_done(1, 1000, 1'b1);
    repeat (3) @(negedge i_clk);
    chk("sm_nbytes", 32'(tx_q.size()), 32'd3);
    chk("sm_b0", 32'(tx_q[0]), 32'h41);
    chk("sm_b1", 32'(tx_q[1]), 32'h42);
    chk("sm_b2", 32'(tx_q[2]), 32'h43);
    chk("sm_ndone", 32'(done_q.size()), 32'd1);
    chk("sm_done_who", 32'(done_q[0]), 32'd0);
    chk("sm_idle_busy", 32'(o_busy), 32'h0);

    // Zero length on requester 2; base equals current address
    clear_logs();
    set_msg(2, 32'h012, 0);
    i_req = 4'b0100;
    @(negedge i_clk);
    chk("zl_done", 32'(o_done), 32'h4);
    chk("zl_grant", 32'(o_grant), 32'h4);
    chk("zl_addr", 32'(o_mem_addr), 32'h012);
    i_req = 4'b0000;
    @(negedge i_clk);
    chk("zl_done_off", 32'(o_done), 32'h0);
    chk("zl_idle", 32'(o_busy), 32'h0);
    repeat (3) @(negedge i_clk);
    chk("zl_no_stb", 32'(stb_cnt), 32'd0);
    chk("zl_addr_hold", 32'(o_mem_addr), 32'h012);

    // Address wrap
    mem[11'h7FE] = 8'hC1; mem[11'h7FF] = 8'hC2; mem[11'h000] = 8'hC3; mem[11'h001] = 8'hC4;
    set_msg(1, 32'h7FE, 4);
    clear_logs();
    i_req = 4'b0010;
    wait_done(1, 1000, 1'b1);
    chk("wr_a0", 32'(addr_q[0]), 32'h7FE);
    chk("wr_a1", 32'(addr_q[1]), 32'h7FF);
    chk("wr_a2", 32'(addr_q[2]), 32'h000);
    chk("wr_a3", 32'(addr_q[3]), 32'h001);
    chk("wr_b3", 32'(tx_q[3]), 32'hC4);

    // Handoff hold: busy forced high 50 cycles while strobing
    mem[11'h100] = 8'hA5; mem[11'h101] = 8'h5A;
    set_msg(3, 32'h100, 2);
    clear_logs();
    hold_busy = 1'b1;
    i_req = 4'b1000;
    cyc = 0;
    while (!o_tx_stb && cyc < 20) begin @(negedge i_clk); cyc++; end
    chk("hd_stb_up", 32'(o_tx_stb), 32'h1);
    hold_bad = 0;
    repeat (50) begin
      @(negedge i_clk);
      if (!o_tx_stb || o_tx_data !== 8'hA5) hold_bad++;
    end
    chk("hd_stable", 32'(hold_bad), 32'd0);
    chk("hd_no_handoff", 32'(tx_q.size()), 32'd0);
    hold_busy = 1'b0;
    wait_done(1, 1000, 1'b1);
    chk("hd_nbytes", 32'(tx_q.size()), 32'd2);
    chk("hd_b0", 32'(tx_q[0]), 32'hA5);
    chk("hd_b1", 32'(tx_q[1]), 32'h5A);

    // Reset in SEND with busy high; afterwards requester 0 wins over 1
    mem[11'h200] = 8'h11; mem[11'h201] = 8'h22; mem[11'h202] = 8'h33;
    set_msg(0, 32'h200, 3);
    clear_logs();
    i_req = 4'b0001;
    cyc = 0;
    while (!(tx_q.size() >= 1 && o_tx_stb && i_tx_busy) && cyc < 200) begin
      @(negedge i_clk); cyc++;
    end
    chk("rm_in_send", 32'(tx_q.size() >= 1 && o_tx_stb && i_tx_busy), 32'h1);
    i_reset_n = 1'b0;
    @(negedge i_clk);
    chk("rm_stb", 32'(o_tx_stb), 32'h0);
    chk("rm_grant", 32'(o_grant), 32'h0);
    chk("rm_done", 32'(o_done), 32'h0);
    chk("rm_no_done", 32'(done_q.size()), 32'd0);
    set_msg(0, 32'h020, 1);
    set_msg(1, 32'h021, 1);
    i_req = 4'b0011;
    grant_q.delete(); done_q.delete();
    i_reset_n = 1'b1;
    wait_done(2, 1000, 1'b1);
    chk("rm_first", 32'(grant_q[0]), 32'd0);
    chk("rm_second", 32'(grant_q[1]), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
